coef_update_sched: RTL
======================

// Module: coef_update_sched
// PURPOSE
//  Frame-synchronous scheduler for scaler coefficient generation. One shared 17-bit restoring divider computes kX and kY in turn.
//  The divider is sequenced on each vertical-sync edge, and new coefficients are committed atomically so the scaler never sees a mixed X/Y pair.
//  Sits between the register/config interface and the scaler Cal and inputCtrl stages, and drives inEn.
// PARAMETERS
//  INPUT_RES_WIDTH   11           width of crop/input resolution fields
//  OUTPUT_RES_WIDTH  11           width of output resolution fields (minus 1)
//  SCALE_BITS        8            coefficient width
//  FRAME_RATE        100          frames/s used in pixel-rate check
//  RATE_LIMIT        27'h7F80000  max permitted outXRes*outYRes*FRAME_RATE (exclusive)
// PORTS
//  clk      in   1                 system clock
//  rst      in   1                 asynchronous active-low reset
//  en       in   1                 scaler enable
//  iVsyn    in   1                 vertical sync, level; rising edge = frame boundary
//  xBgn     in   INPUT_RES_WIDTH   crop left edge
//  xEnd     in   INPUT_RES_WIDTH   crop right edge
//  yBgn     in   INPUT_RES_WIDTH   crop top edge
//  yEnd     in   INPUT_RES_WIDTH   crop bottom edge
//  outXRes  in   OUTPUT_RES_WIDTH  output width minus 1
//  outYRes  in   OUTPUT_RES_WIDTH  output height minus 1
//  kX       out  SCALE_BITS        committed X coefficient
//  kY       out  SCALE_BITS        committed Y coefficient
//  inEn     out  1                 enable to inputCtrl
//  busy     out  1                 calculation in progress
//  updDone  out  1                 1-cycle pulse on commit
//  cfgErr   out  1                 sticky until next successful commit: bad crop, zero divisor or rate fail
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; the iVsyn edge register clears to 0.
//  iVsyn is double-registered before edge detection (2-cycle sync delay).
//  FSM: IDLE -> LOAD -> DIV_X -> DIV_Y -> CHECK -> COMMIT -> IDLE.
//  IDLE: leave on a synced iVsyn rising edge while en=1.
//  LOAD (1 cycle): latch all config inputs.
//    dividend = {(end-bgn+1), 6'b0}, 17 bits, truncated.
//    divisor  = {6'b0, outRes}.
//  DIV_X/DIV_Y: 17 cycles each on the shared divider (start pulse, then wait for done).
//  CHECK (1 cycle): raise the error flag if any of:
//    xEnd<xBgn or yEnd<yBgn;
//    outXRes==0 or outYRes==0;
//    the rate check fails.
//  COMMIT (1 cycle):
//    No error: kX = q_x[7:0]+1 and kY = q_y[7:0]+1 (8-bit wrap); pulse updDone; inEn=1; cfgErr=0.
//    Error: kX and kY keep their old values; inEn=0; cfgErr=1.
//  Latency: synced edge to updDone = 1+17+17+1+1 = 37 cycles. busy=1 in every non-IDLE state.
//  iVsyn edge while busy: set a one-deep pending flag; one rerun starts from IDLE the cycle after COMMIT; further edges are merged.
//  en falling while busy: abort to IDLE; inEn=0 next cycle; kX/kY unchanged; pending cleared.
//  en=0 in IDLE: inEn=0. inEn rises only through COMMIT.
//  Zero divisor: divider returns 17'h1FFFF. The quotient is discarded by the error path.
//  Async reset mid-divide: immediate return to reset values; no partial commit.
// CONFIGURATION
//  `COEF_RATE_CHECK_EN defined: CHECK also computes outXRes*outYRes*FRAME_RATE (33-bit) and flags an error if the result is >= RATE_LIMIT.
//  This multiply is a 2-stage pipeline that overlaps DIV_X.
//  Macro undefined: no multiplier; the rate check always passes.
// STRUCTURE
//  Package scaler_pkg: FSM state encoding, DIV_W=17, FRAC_BITS=6, FRAME_RATE/RATE_LIMIT defaults.
//  Sub-module seq_div17: restoring divider, 1 quotient bit per cycle.
//    Ports: clk, rst, start, dividend, divisor -> quotient, done.
//  All sequencing and commit logic lives in this module.
// TESTING
//  1. xBgn=0,xEnd=639,outXRes=1279; yBgn=0,yEnd=479,outYRes=719; en=1; iVsyn edge -> 37 cycles after the synced edge: kX=33, kY=43, updDone pulse, inEn=1.
//  2. Macro on; outXRes=1919, outYRes=1079 -> cfgErr=1, inEn=0, kX/kY hold previous values.
//  3. Macro off; same config as 2 -> commit succeeds, cfgErr=0.
//  4. xEnd=10, xBgn=20 -> cfgErr=1, no updDone.
//  5. Second iVsyn edge at cycle 10 of DIV_X -> exactly one rerun; updDone pulses twice in total.
//  6. en=0 during DIV_Y, or rst=0 mid-divide -> abort, busy=0, inEn=0, coefficients unchanged (reset case: all zero).

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler coefficient scheduler.
// The optional pixel-rate check is enabled with `COEF_RATE_CHECK_EN (see coef_update_sched).
package scaler_pkg;

    // Shared divider geometry: 11-bit span with 6 fractional bits.
    localparam int DIV_W     = 17;
    localparam int FRAC_BITS = 6;

    // Pixel-rate check defaults.
    localparam int          FRAME_RATE_DEF = 100;
    localparam logic [26:0] RATE_LIMIT_DEF = 27'h7F80000;

    // Scheduler FSM encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_DIV_X  = 3'd2;
    localparam logic [2:0] ST_DIV_Y  = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_COMMIT = 3'd5;

endpackage

// File: rtl/seq_div17.sv
// Restoring divider, one quotient bit per cycle, DIV_W (17) cycles per divide.
// The first step is taken on the start edge itself, so done is high on the
// cycle after the 17th step and the quotient is held until the next start.
// A zero divisor yields an all-ones quotient.
module seq_div17
    import scaler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_W - 1);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] dvs_q;
    logic [4:0]       cnt_q;
    logic             active_q;

    logic [DIV_W-1:0] rem_in;
    logic [DIV_W-1:0] quo_in;
    logic [DIV_W-1:0] dvs_in;
    logic [DIV_W:0]   shifted;
    logic             fits;
    logic [DIV_W-1:0] rem_nx;
    logic [DIV_W-1:0] quo_nx;

    // One restoring step; on start the step runs on the fresh operands.
    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[DIV_W-1]};
        fits    = (shifted >= {1'b0, dvs_in});
        rem_nx  = fits ? DIV_W'(shifted - {1'b0, dvs_in}) : shifted[DIV_W-1:0];
        quo_nx  = {quo_in[DIV_W-2:0], fits};
    end

    // Step sequencing and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= rem_nx;
                quo_q    <= quo_nx;
                dvs_q    <= dvs_in;
                cnt_q    <= 5'd1;
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/coef_update_sched.sv
// Frame-synchronous scheduler for scaler coefficients kX/kY.
// On each synced iVsyn rising edge (while en=1) the config is latched, kX and
// kY are computed in turn on one shared seq_div17, validated, and committed
// together so the scaler never sees a mixed pair.
// Optional: define COEF_RATE_CHECK_EN to add the outXRes*outYRes*FRAME_RATE
// limit check (2-stage multiply running alongside DIV_X).
module coef_update_sched
    import scaler_pkg::*;
#(
    parameter int          INPUT_RES_WIDTH  = 11,
    parameter int          OUTPUT_RES_WIDTH = 11,
    parameter int          SCALE_BITS       = 8,
    parameter int          FRAME_RATE       = FRAME_RATE_DEF,
    parameter logic [26:0] RATE_LIMIT       = RATE_LIMIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        iVsyn,
    input  logic [INPUT_RES_WIDTH-1:0]  xBgn,
    input  logic [INPUT_RES_WIDTH-1:0]  xEnd,
    input  logic [INPUT_RES_WIDTH-1:0]  yBgn,
    input  logic [INPUT_RES_WIDTH-1:0]  yEnd,
    input  logic [OUTPUT_RES_WIDTH-1:0] outXRes,
    input  logic [OUTPUT_RES_WIDTH-1:0] outYRes,
    output logic [SCALE_BITS-1:0]       kX,
    output logic [SCALE_BITS-1:0]       kY,
    output logic                        inEn,
    output logic                        busy,
    output logic                        updDone,
    output logic                        cfgErr
);

    // {span, 6'b0} with the span wrapping at the input field width.
    function automatic logic [DIV_W-1:0] mk_dividend(input logic [INPUT_RES_WIDTH-1:0] e,
                                                     input logic [INPUT_RES_WIDTH-1:0] b);
        logic [INPUT_RES_WIDTH-1:0] span;
        span = e - b + INPUT_RES_WIDTH'(1);
        return DIV_W'({span, {FRAC_BITS{1'b0}}});
    endfunction

    logic [2:0] state_q;
    logic       vs_s1, vs_s2, vs_s3;
    logic       vs_rise;
    logic       pend_q;
    logic       err_q;

    logic [INPUT_RES_WIDTH-1:0]  xbgn_q, xend_q, ybgn_q, yend_q;
    logic [OUTPUT_RES_WIDTH-1:0] oxres_q, oyres_q;
    logic [SCALE_BITS-1:0]       qx_q, qy_q;

    logic             div_start;
    logic [DIV_W-1:0] div_dividend;
    logic [DIV_W-1:0] div_divisor;
    logic [DIV_W-1:0] div_q;
    logic             div_done;
    logic             cfg_bad;
    logic             rate_fail;
    logic             unused_q_hi;

    assign vs_rise = vs_s2 & ~vs_s3;
    assign busy    = (state_q != ST_IDLE);

    // X divide is launched straight from the ports during LOAD (the same values
    // being latched), so DIV_X sees its quotient exactly 17 cycles later; Y is
    // launched from the latched copy on the cycle DIV_X completes.
    always_comb begin
        div_start    = (state_q == ST_LOAD) || ((state_q == ST_DIV_X) && div_done);
        div_dividend = mk_dividend(yend_q, ybgn_q);
        div_divisor  = DIV_W'(oyres_q);
        if (state_q == ST_LOAD) begin
            div_dividend = mk_dividend(xEnd, xBgn);
            div_divisor  = DIV_W'(outXRes);
        end
    end

    seq_div17 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_q),
        .done     (div_done)
    );

    // Only the low SCALE_BITS of each quotient form the coefficient.
    assign unused_q_hi = &{1'b0, div_q[DIV_W-1:SCALE_BITS]};

    // Bad crop window or zero output size.
    always_comb begin
        cfg_bad = (xend_q < xbgn_q) || (yend_q < ybgn_q) ||
                  (oxres_q == '0) || (oyres_q == '0);
    end

`ifdef COEF_RATE_CHECK_EN
    localparam int PW = 2 * OUTPUT_RES_WIDTH;

    logic [PW-1:0] res_prod_q;
    logic [32:0]   rate_q;

    // Two-stage rate multiply off the latched resolutions; settled long before CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_prod_q <= '0;
            rate_q     <= '0;
        end else begin
            res_prod_q <= PW'(oxres_q) * PW'(oyres_q);
            rate_q     <= 33'(res_prod_q) * 33'(FRAME_RATE);
        end
    end

    assign rate_fail = (rate_q >= 33'(RATE_LIMIT));
`else
    assign rate_fail = 1'b0;
`endif

    // Sync, frame sequencing, pending rerun and atomic commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_s3   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            xbgn_q  <= '0;
            xend_q  <= '0;
            ybgn_q  <= '0;
            yend_q  <= '0;
            oxres_q <= '0;
            oyres_q <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            kX      <= '0;
            kY      <= '0;
            inEn    <= 1'b0;
            updDone <= 1'b0;
            cfgErr  <= 1'b0;
        end else begin
            vs_s1   <= iVsyn;
            vs_s2   <= vs_s1;
            vs_s3   <= vs_s2;
            updDone <= 1'b0;
            if (!en) begin
                inEn <= 1'b0;
            end

            if (state_q == ST_IDLE) begin
                if (!en) begin
                    pend_q <= 1'b0;
                end else if (vs_rise || pend_q) begin
                    pend_q  <= 1'b0;
                    state_q <= ST_LOAD;
                end
            end else if (!en) begin
                // Abort: coefficients untouched, no rerun.
                pend_q  <= 1'b0;
                state_q <= ST_IDLE;
            end else begin
                if (vs_rise) begin
                    pend_q <= 1'b1;
                end
                case (state_q)
                    ST_LOAD: begin
                        xbgn_q  <= xBgn;
                        xend_q  <= xEnd;
                        ybgn_q  <= yBgn;
                        yend_q  <= yEnd;
                        oxres_q <= outXRes;
                        oyres_q <= outYRes;
                        state_q <= ST_DIV_X;
                    end
                    ST_DIV_X: begin
                        if (div_done) begin
                            qx_q    <= div_q[SCALE_BITS-1:0];
                            state_q <= ST_DIV_Y;
                        end
                    end
                    ST_DIV_Y: begin
                        if (div_done) begin
                            qy_q    <= div_q[SCALE_BITS-1:0];
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        err_q   <= cfg_bad || rate_fail;
                        state_q <= ST_COMMIT;
                    end
                    ST_COMMIT: begin
                        if (err_q) begin
                            inEn   <= 1'b0;
                            cfgErr <= 1'b1;
                        end else begin
                            kX      <= qx_q + SCALE_BITS'(1);
                            kY      <= qy_q + SCALE_BITS'(1);
                            inEn    <= 1'b1;
                            cfgErr  <= 1'b0;
                            updDone <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
